// File: rtl/ramp_samp_pkg.sv
// Shared types and constants for the two-channel ramp-and-sample ADC sequencer.
// STATUS register bit positions live here so the register bank and the sequencer agree.
package ramp_samp_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    DISCHARGE = 2'd1,
    RAMP      = 2'd2,
    DONE      = 2'd3
  } state_t;

  localparam int unsigned WIDTH_RAMP_AND_SAMP_DEF = 8;
  localparam int unsigned DISCHARGE_CYCLES_DEF    = 16;
  localparam int unsigned CLK_DIV_DEF             = 4;

  localparam int unsigned STATUS_VALID_LSB   = 0;
  localparam int unsigned STATUS_TIMEOUT_BIT = 2;
  localparam int unsigned STATUS_BUSY_BIT    = 3;
  localparam int unsigned STATUS_DONE_BIT    = 4;
  localparam int unsigned STATUS_W           = 5;

  function automatic logic [STATUS_W-1:0] pack_status(input logic [1:0] v,
                                                      input logic       t,
                                                      input logic       b,
                                                      input logic       d);
    logic [STATUS_W-1:0] s;
    s = '0;
    s[STATUS_VALID_LSB +: 2] = v;
    s[STATUS_TIMEOUT_BIT]    = t;
    s[STATUS_BUSY_BIT]       = b;
    s[STATUS_DONE_BIT]       = d;
    return s;
  endfunction

endpackage

// File: rtl/cmp_sync_edge.sv
// Two-flop synchronizer for one asynchronous comparator output, followed by an
// edge register; rise pulses for one clk on a synchronized 0->1 transition.
module cmp_sync_edge (
  input  logic clk,
  input  logic reset_n,
  input  logic async_in,
  output logic rise
);

  logic meta_q;
  logic sync_q;
  logic prev_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      meta_q <= async_in;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign rise = sync_q & ~prev_q;

endmodule

// File: rtl/ramp_samp_sequencer.sv
// Ramp-and-sample ADC sequencer: discharges the ramp, releases it, counts
// prescaled ticks and captures the count when each channel's comparator trips.
module ramp_samp_sequencer
  import ramp_samp_pkg::*;
#(
  parameter int unsigned WIDTH_RAMP_AND_SAMP = WIDTH_RAMP_AND_SAMP_DEF,
  parameter int unsigned DISCHARGE_CYCLES    = DISCHARGE_CYCLES_DEF,
  parameter int unsigned CLK_DIV             = CLK_DIV_DEF
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic                           run,
  input  logic [1:0]                     cmp_in,
  output logic                           ramp_discharge,
  output logic                           ramp_en,
  output logic [WIDTH_RAMP_AND_SAMP-1:0] count0,
  output logic [WIDTH_RAMP_AND_SAMP-1:0] count1,
  output logic [1:0]                     valid,
  output logic                           busy,
  output logic                           done,
  output logic                           timeout
);

  localparam int unsigned W  = WIDTH_RAMP_AND_SAMP;
  localparam int unsigned DW = $clog2(DISCHARGE_CYCLES + 1);
  localparam int unsigned PW = $clog2(CLK_DIV + 1);

  localparam logic [W-1:0]  CNT_MAX     = '1;
  localparam logic [W-1:0]  CNT_PRE_MAX = CNT_MAX - W'(1);
  localparam logic [DW-1:0] DIS_LAST    = DW'(DISCHARGE_CYCLES - 1);
  localparam logic [PW-1:0] PRESC_LAST  = PW'(CLK_DIV - 1);

  state_t        state_q, state_d;
  logic [DW-1:0] dcnt_q, dcnt_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [W-1:0]  cnt_q, cnt_d;
  logic [W-1:0]  count0_d, count1_d;
  logic [1:0]    valid_d;
  logic          timeout_d;
  logic          run_low_q;
  logic [1:0]    trip;
  logic          tick;
  logic          sat;
  logic [W-1:0]  cap_val;

  cmp_sync_edge u_sync0 (
    .clk      (clk),
    .reset_n  (reset_n),
    .async_in (cmp_in[0]),
    .rise     (trip[0])
  );

  cmp_sync_edge u_sync1 (
    .clk      (clk),
    .reset_n  (reset_n),
    .async_in (cmp_in[1]),
    .rise     (trip[1])
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= IDLE;
      dcnt_q         <= '0;
      presc_q        <= '0;
      cnt_q          <= '0;
      count0         <= '0;
      count1         <= '0;
      valid          <= '0;
      timeout        <= 1'b0;
      run_low_q      <= 1'b0;
      ramp_discharge <= 1'b1;
      ramp_en        <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
    end else begin
      state_q        <= state_d;
      dcnt_q         <= dcnt_d;
      presc_q        <= presc_d;
      cnt_q          <= cnt_d;
      count0         <= count0_d;
      count1         <= count1_d;
      valid          <= valid_d;
      timeout        <= timeout_d;
      run_low_q      <= ~run;
      ramp_discharge <= (state_d != RAMP);
      ramp_en        <= (state_d == RAMP);
      busy           <= (state_d == DISCHARGE) || (state_d == RAMP);
      done           <= (state_d == DONE);
    end
  end

  // A start needs run seen low on the previous clk, so run held high through
  // DONE or across reset release cannot retrigger a conversion.
  always_comb begin
    state_d   = state_q;
    dcnt_d    = dcnt_q;
    presc_d   = presc_q;
    cnt_d     = cnt_q;
    count0_d  = count0;
    count1_d  = count1;
    valid_d   = valid;
    timeout_d = timeout;
    tick      = 1'b0;
    sat       = 1'b0;
    cap_val   = cnt_q;

    case (state_q)
      IDLE: begin
        if (run && run_low_q) begin
          state_d   = DISCHARGE;
          dcnt_d    = '0;
          count0_d  = '0;
          count1_d  = '0;
          valid_d   = '0;
          timeout_d = 1'b0;
        end
      end

      DISCHARGE: begin
        if (!run) begin
          state_d   = IDLE;
          count0_d  = '0;
          count1_d  = '0;
          valid_d   = '0;
          timeout_d = 1'b0;
        end else if (dcnt_q == DIS_LAST) begin
          state_d = RAMP;
          presc_d = '0;
          cnt_d   = '0;
        end else begin
          dcnt_d = dcnt_q + 1'b1;
        end
      end

      RAMP: begin
        if (!run) begin
          state_d   = IDLE;
          count0_d  = '0;
          count1_d  = '0;
          valid_d   = '0;
          timeout_d = 1'b0;
        end else if (valid == 2'b11) begin
          state_d = DONE;
        end else begin
          tick    = (presc_q == PRESC_LAST);
          presc_d = tick ? '0 : presc_q + 1'b1;
          // Saturation is the tick that lands the counter on all-ones; a trip
          // in that same cycle records the saturated value.
          sat     = tick && (cnt_q == CNT_PRE_MAX);
          if (tick) begin
            cnt_d = cnt_q + 1'b1;
          end
          cap_val = sat ? CNT_MAX : cnt_q;

          if (trip[0] && !valid[0]) begin
            count0_d   = cap_val;
            valid_d[0] = 1'b1;
          end
          if (trip[1] && !valid[1]) begin
            count1_d   = cap_val;
            valid_d[1] = 1'b1;
          end

          if (sat) begin
            if (!valid_d[0]) begin
              count0_d = CNT_MAX;
            end
            if (!valid_d[1]) begin
              count1_d = CNT_MAX;
            end
            timeout_d = (valid_d != 2'b11);
            state_d   = DONE;
          end
        end
      end

      DONE: begin
        if (!run) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_ramp_samp_sequencer.sv
// Scoreboard bench for ramp_samp_sequencer: stimulus pushes the expected result
// of each conversion, a monitor pops and compares when done rises.
module tb_ramp_samp_sequencer;
  import ramp_samp_pkg::*;

  logic       clk;
  logic       reset_n;
  logic       run;
  logic [1:0] cmp_in;
  logic       ramp_discharge;
  logic       ramp_en;
  logic [7:0] count0;
  logic [7:0] count1;
  logic [1:0] valid;
  logic       busy;
  logic       done;
  logic       timeout;

  typedef struct {
    logic [7:0] c0;
    logic [7:0] c1;
    logic [1:0] v;
    logic       to;
  } exp_t;

  exp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;
  logic done_prev = 1'b0;

  ramp_samp_sequencer #(
    .WIDTH_RAMP_AND_SAMP (8),
    .DISCHARGE_CYCLES    (16),
    .CLK_DIV             (4)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .run            (run),
    .cmp_in         (cmp_in),
    .ramp_discharge (ramp_discharge),
    .ramp_en        (ramp_en),
    .count0         (count0),
    .count1         (count1),
    .valid          (valid),
    .busy           (busy),
    .done           (done),
    .timeout        (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_exp(input logic [7:0] c0, input logic [7:0] c1,
                          input logic [1:0] v, input logic to);
    exp_t e;
    e.c0 = c0; e.c1 = c1; e.v = v; e.to = to;
    exp_q.push_back(e);
  endtask

  // Counts posedges from the current negedge until ramp_en is seen high.
  task automatic wait_ramp_en(output int edges);
    edges = 0;
    while (!ramp_en && edges < 100) begin
      @(negedge clk);
      edges++;
    end
    if (!ramp_en) begin
      tests++; fails++;
      $display("FAIL wait_ramp_en: ramp_en still 0 after %0d clk, expected 1", edges);
    end
  endtask

  task automatic wait_done(input int max_cyc, output int n);
    n = 0;
    while (!done && n < max_cyc) begin
      @(negedge clk);
      n++;
    end
    if (!done) begin
      tests++; fails++;
      $display("FAIL wait_done: done still 0 after %0d clk, expected 1", n);
    end
  endtask

  task automatic wait_ticks(input int t);
    repeat (t * 4) @(negedge clk);
  endtask

  task automatic end_run();
    @(negedge clk);
    run = 1'b0;
    cmp_in = 2'b00;
    repeat (5) @(negedge clk);
  endtask

  // Monitor: every rising edge of done must match the next queued result.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (done && !done_prev) begin
        if (exp_q.size() == 0) begin
          tests++; fails++;
          $display("FAIL sb_unexpected_done: done rose with empty scoreboard, expected no completion");
        end else begin
          e = exp_q.pop_front();
          check("sb_count0",  count0,  e.c0);
          check("sb_count1",  count1,  e.c1);
          check("sb_valid",   valid,   e.v);
          check("sb_timeout", timeout, e.to);
          check("sb_busy",    busy,    0);
          check("sb_ramp_en", ramp_en, 0);
        end
      end
      done_prev = done;
    end
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not complete, expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int e;
    int n;
    reset_n = 1'b0;
    run     = 1'b0;
    cmp_in  = 2'b00;
    repeat (2) @(negedge clk);
    check("rst_discharge", ramp_discharge, 1);
    check("rst_ramp_en",   ramp_en, 0);
    check("rst_counts",    {count1, count0}, 0);
    check("rst_status",    pack_status(valid, timeout, busy, done), 5'b00000);
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    check("idle_after_rst_busy", busy, 0);

    // Basic conversion: ch0 at tick 40, ch1 at tick 100.
    push_exp(8'd40, 8'd100, 2'b11, 1'b0);
    run = 1'b1;
    wait_ramp_en(e);
    check("ramp_en_latency", e, 17);
    check("ramp_release", ramp_discharge, 0);
    check("busy_in_ramp", busy, 1);
    wait_ticks(40);
    cmp_in[0] = 1'b1;
    wait_ticks(60);
    cmp_in[1] = 1'b1;
    wait_done(500, n);

    // Hold: cmp glitching with run high must not disturb the result.
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      cmp_in = ~cmp_in;
    end
    repeat (5) @(negedge clk);
    check("hold_count0", count0, 40);
    check("hold_count1", count1, 100);
    check("hold_status", pack_status(valid, timeout, busy, done), 5'b10011);
    check("hold_discharge", ramp_discharge, 1);
    cmp_in = 2'b00;
    @(negedge clk);
    run = 1'b0;
    @(negedge clk);
    check("idle_done_clear", done, 0);
    check("idle_keep_count0", count0, 40);
    check("idle_keep_count1", count1, 100);
    repeat (4) @(negedge clk);

    // Timeout: ch0 at tick 10, ch1 never; saturates after 255 ticks.
    push_exp(8'd10, 8'hFF, 2'b01, 1'b1);
    run = 1'b1;
    wait_ramp_en(e);
    wait_ticks(10);
    cmp_in[0] = 1'b1;
    wait_done(1200, n);
    check("timeout_latency", n, 980);
    end_run();

    // Abort mid-ramp at tick 50 after ch0 has captured.
    run = 1'b1;
    wait_ramp_en(e);
    wait_ticks(10);
    cmp_in[0] = 1'b1;
    wait_ticks(40);
    check("pre_abort_valid", valid, 2'b01);
    check("pre_abort_count0", count0, 10);
    run = 1'b0;
    @(negedge clk);
    check("abort_discharge", ramp_discharge, 1);
    check("abort_ramp_en", ramp_en, 0);
    check("abort_valid", valid, 0);
    check("abort_counts", {count1, count0}, 0);
    check("abort_busy", busy, 0);
    cmp_in = 2'b00;
    repeat (4) @(negedge clk);

    // Restart, then both channels trip in the same clk at tick 20.
    push_exp(8'd20, 8'd20, 2'b11, 1'b0);
    run = 1'b1;
    @(negedge clk);
    check("restart_busy", busy, 1);
    check("restart_discharge", ramp_discharge, 1);
    wait_ramp_en(e);
    check("restart_ramp_latency", e, 16);
    wait_ticks(20);
    cmp_in = 2'b11;
    n = 0;
    while (valid != 2'b11 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("simul_capture_delay", n, 3);
    check("simul_done_not_yet", done, 0);
    @(negedge clk);
    check("simul_done_next", done, 1);
    end_run();

    // Channel 0 already high before the ramp: never trips, run times out.
    cmp_in[0] = 1'b1;
    repeat (4) @(negedge clk);
    push_exp(8'hFF, 8'd30, 2'b10, 1'b1);
    run = 1'b1;
    wait_ramp_en(e);
    wait_ticks(30);
    cmp_in[1] = 1'b1;
    wait_done(1200, n);
    end_run();

    // Asynchronous reset in the middle of a ramp.
    run = 1'b1;
    wait_ramp_en(e);
    wait_ticks(5);
    @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    check("async_rst_discharge", ramp_discharge, 1);
    check("async_rst_ramp_en", ramp_en, 0);
    check("async_rst_counts", {count1, count0}, 0);
    check("async_rst_status", pack_status(valid, timeout, busy, done), 5'b00000);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (5) @(negedge clk);
    check("rst_run_high_stays_idle", busy, 0);
    check("rst_run_high_discharge", ramp_discharge, 1);
    run = 1'b0;
    @(negedge clk);
    run = 1'b1;
    @(negedge clk);
    check("rst_rerun_busy", busy, 1);
    end_run();

    check("scoreboard_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
